// File: rtl/writeback_arbiter_if.sv
// Register-file writeback bundle: pipeline writes, MDU issue/result handshake,
// register-file write port and the status outputs seen by the hazard unit.
interface writeback_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 16
);
  logic                  wb_en;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  logic                  issue_en;
  logic [ADDR_WIDTH-1:0] issue_rd;

  logic                  mdu_valid;
  logic                  mdu_ready;
  logic [ADDR_WIDTH-1:0] mdu_rd;
  logic [DATA_WIDTH-1:0] mdu_data;

  logic                  rf_en;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_data;

  logic [NUM_REGS-1:0]   pending;
  logic                  stall_req;
  logic [1:0]            fifo_count;
  logic                  waw_err;

  modport master (
    output wb_en, wb_rd, wb_data,
    output issue_en, issue_rd,
    output mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready,
    input  rf_en, rf_rd, rf_data,
    input  pending, stall_req, fifo_count, waw_err
  );

  modport slave (
    input  wb_en, wb_rd, wb_data,
    input  issue_en, issue_rd,
    input  mdu_valid, mdu_rd, mdu_data,
    output mdu_ready,
    output rf_en, rf_rd, rf_data,
    output pending, stall_req, fifo_count, waw_err
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges pipeline writebacks with queued MDU results onto the single GPR write
// port, tracks outstanding MDU destinations and requests stalls on starvation.
module writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int NUM_REGS     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  writeback_arbiter_if.slave  bus
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  wb_req_t [1:0]         fifo_q, fifo_d;
  logic [1:0]            count_q, count_d;
  logic [CW-1:0]         starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic                  waw_q, waw_d;
  logic                  rf_en_q, rf_en_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  logic    ready, push, pop;
  wb_req_t head, incoming;

  // Ready and pop both look only at registered occupancy, so a result pushed
  // into an empty FIFO waits a cycle and a same-cycle pop never frees a slot.
  assign ready    = (count_q != 2'd2);
  assign push     = bus.mdu_valid & ready;
  assign pop      = ~bus.wb_en & (count_q != 2'd0);
  assign head     = fifo_q[0];
  assign incoming = {bus.mdu_rd, bus.mdu_data};

  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        fifo_d[count_q[0]] = incoming;
        count_d            = count_q + 2'd1;
      end
      2'b01: begin
        fifo_d[0] = fifo_q[1];
        count_d   = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          fifo_d[0] = incoming;
        end else begin
          fifo_d[0] = fifo_q[1];
          fifo_d[1] = incoming;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rf_en_d   = bus.wb_en | pop;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (bus.wb_en) begin
      rf_rd_d   = bus.wb_rd;
      rf_data_d = bus.wb_data;
    end else if (pop) begin
      rf_rd_d   = head.rd;
      rf_data_d = head.data;
    end
  end

  // Clear before set so a same-register issue in the pop cycle stays pending.
  always_comb begin
    pending_d = pending_q;
    if (pop)          pending_d[head.rd]      = 1'b0;
    if (bus.issue_en) pending_d[bus.issue_rd] = 1'b1;
  end

  always_comb begin
    if (pop || count_q == 2'd0) starve_d = '0;
    else if (starve_q >= LIMIT) starve_d = starve_q;
    else                        starve_d = starve_q + CW'(1);
    // Once raised, the stall holds until the FIFO has fully drained.
    stall_d = (count_q != 2'd0) & (stall_q | (starve_q >= LIMIT));
    waw_d   = waw_q
            | (bus.issue_en & pending_q[bus.issue_rd])
            | (bus.wb_en    & pending_q[bus.wb_rd]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q    <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      waw_q     <= 1'b0;
      rf_en_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      pending_q <= '0;
    end else begin
      fifo_q    <= fifo_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      waw_q     <= waw_d;
      rf_en_q   <= rf_en_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      pending_q <= pending_d;
    end
  end

  assign bus.mdu_ready  = ready;
  assign bus.rf_en      = rf_en_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_data    = rf_data_q;
  assign bus.pending    = pending_q;
  assign bus.stall_req  = stall_q;
  assign bus.fifo_count = count_q;
  assign bus.waw_err    = waw_q;

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Final pipeline stage feeding the general-purpose register file's single write port (en/rd/data).
- Merges the in-order pipeline writeback stream with results from the multi-cycle mult/div unit (MDU) using a 2-entry result FIFO.
- Keeps a pending-destination scoreboard that the hazard unit uses to stall readers of outstanding MDU results.
- Forces an upstream stall when MDU results are starved.

Parameters:
- DATA_WIDTH, 32, GPR width.
- ADDR_WIDTH, 4, register address width.
- NUM_REGS, 16, registers tracked by the scoreboard.
- STARVE_LIMIT, 4, cycles a FIFO head may wait before stall_req is raised (legal range 1-15).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_en  in  1  pipeline writeback valid; cannot be back-pressured.
- wb_rd  in  ADDR_WIDTH  pipeline destination.
- wb_data  in  DATA_WIDTH  pipeline result.
- issue_en  in  1  MDU op issued this cycle.
- issue_rd  in  ADDR_WIDTH  destination of the issued MDU op.
- mdu_valid  in  1  MDU result valid.
- mdu_ready  out  1  FIFO can accept a result.
- mdu_rd  in  ADDR_WIDTH  MDU result destination.
- mdu_data  in  DATA_WIDTH  MDU result.
- rf_en  out  1  register file write enable.
- rf_rd  out  ADDR_WIDTH  register file write address.
- rf_data  out  DATA_WIDTH  register file write data.
- pending  out  NUM_REGS  scoreboard; bit i set means an MDU result for register i is outstanding.
- stall_req  out  1  upstream must hold so that wb_en is 0.
- fifo_count  out  2  FIFO occupancy, 0-2.
- waw_err  out  1  sticky ordering-violation flag.

Behaviour:
- Reset (rst=0, asynchronous): rf_en=0, rf_rd=0, rf_data=0, pending=0, fifo_count=0, stall_req=0, waw_err=0, starvation counter=0.
- Outputs rf_* are registered. The write selected in cycle N appears on rf_* in cycle N+1, so the register file commits at the end of N+1.
- FIFO handshake:
  - mdu_ready = (fifo_count < 2), derived from registered count only; a same-cycle pop does not raise it.
  - A push occurs when mdu_valid & mdu_ready. The entry is {mdu_rd, mdu_data}.
  - mdu_valid with mdu_ready=0 is held by the MDU; nothing is lost.
- Write selection each cycle:
  - If wb_en: select {wb_rd, wb_data}; no pop.
  - Else if fifo_count>0: select the FIFO head and pop it.
  - Else: rf_en=0 next cycle, and rf_rd/rf_data hold their previous values.
- Simultaneous push and pop: FIFO order is preserved and the count is unchanged. A push into an empty FIFO is not eligible for popping until the next cycle (no bypass).
- Scoreboard:
  - issue_en sets pending[issue_rd].
  - A pop clears pending[head rd].
  - Same cycle, same register (set and clear): set wins.
  - Clears take effect from the cycle after the pop. pending therefore drops in the same cycle the register file write is presented.
- Starvation:
  - The counter increments each cycle that fifo_count>0 and no pop occurs. It clears on a pop or when fifo_count=0.
  - When counter reaches STARVE_LIMIT, stall_req is registered high from the next cycle.
  - stall_req stays high until the FIFO is empty, then deasserts the following cycle.
  - If wb_en arrives while stall_req=1, the pipeline write still wins.
- waw_err is set (sticky until reset) on either event:
  - issue_en while pending[issue_rd] is already 1.
  - wb_en with pending[wb_rd]=1.
- Ordering errors are flagged only; the data path still behaves per the selection rules above.
- Reset mid-operation clears the FIFO contents and the scoreboard; queued MDU results are discarded.

Test Plan:
- Reset, then wb_en=1, wb_rd=3, wb_data=0xDEADBEEF for one cycle -> next cycle rf_en=1, rf_rd=3, rf_data=0xDEADBEEF; following cycle rf_en=0.
- issue_en, issue_rd=5; later push MDU result rd=5, data=0x12345678 with wb_en=0 -> pending[5]=1 until pop; rf_* shows 5/0x12345678 one cycle after the pop cycle; pending[5]=0 that same cycle.
- Two MDU pushes (rd=1, rd=2) with wb_en held 1 -> fifo_count=2, mdu_ready=0; a third mdu_valid stalls; after wb_en drops, rf writes occur in order rd 1 then rd 2, and mdu_ready returns.
- FIFO holds one entry, wb_en=1 continuously, STARVE_LIMIT=4 -> stall_req rises after 4 waiting cycles; after wb_en drops the entry is written, and stall_req falls the cycle after fifo_count reaches 0.
- issue_en rd=7 twice without a pop -> waw_err=1 and stays 1. Then wb_en with wb_rd=7 -> the write is still performed; waw_err remains 1.
- Assert rst=0 mid-cycle with fifo_count=2 and pending nonzero -> all outputs 0 immediately; after release no rf_en pulses occur.
